// File: rtl/rr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// rr_encoder_pkg
// Shared definitions for the round-robin request encoder:
//   - state_t      : two-state handshake FSM encoding (IDLE / HOLD)
//   - REQ_MAX_W    : widest request vector the helper functions accept
//   - clog2()      : constant ceil(log2()) used to size the pointer/grant
//   - multi_hot()  : true when more than one bit of a vector is set
// ---------------------------------------------------------------------------
package rr_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int REQ_MAX_W = 64;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Clearing the lowest set bit leaves something behind only if at least
    // two bits were set, so no adder tree is needed.
    function automatic logic multi_hot(input logic [REQ_MAX_W-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/rr_encoder_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority search: returns the index of the first set
// request bit at or above ptr, wrapping from N_REQ-1 back to 0.
// Ports:
//   req   [N_REQ-1:0] request lines
//   ptr   [PTR_W-1:0] search start index (always < N_REQ)
//   grant [PTR_W-1:0] index of the selected request line
//   any               at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
    import rr_encoder_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant,
    output logic             any
);

    logic [2*N_REQ-1:0]            w_dbl;
    logic [N_REQ-1:0]              w_rot;
    logic [N_REQ-1:0]              w_first;
    logic [PTR_W-1:0][N_REQ-1:0]   w_sel;
    logic [PTR_W-1:0]              w_off;
    logic [PTR_W:0]                w_sum;

    // Rotate so that bit ptr lands on position 0; a doubled vector makes the
    // wrap-around a plain right shift.
    assign w_dbl = {req, req};
    assign w_rot = N_REQ'(w_dbl >> ptr);
    assign any   = |req;

    // One-hot mask of the lowest set bit of the rotated vector.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_first
        if (gi == 0) begin : g_lsb
            assign w_first[gi] = w_rot[0];
        end else begin : g_upper
            assign w_first[gi] = w_rot[gi] & ~(|w_rot[gi-1:0]);
        end
    end

    // One-hot to binary: offset bit bi is the OR of every position whose
    // index has bit bi set.
    for (genvar bi = 0; bi < PTR_W; bi++) begin : g_off_bit
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_term
            if (((gi >> bi) & 1) != 0) begin : g_on
                assign w_sel[bi][gi] = w_first[gi];
            end else begin : g_off
                assign w_sel[bi][gi] = 1'b0;
            end
        end
        assign w_off[bi] = |w_sel[bi];
    end

    // Undo the rotation: (ptr + offset) mod N_REQ.
    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign grant = (w_sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(w_sum - (PTR_W+1)'(N_REQ))
                                                : PTR_W'(w_sum);

endmodule

// File: rtl/rr_encoder.sv
// ---------------------------------------------------------------------------
// rr_encoder
// Converts N_REQ request lines into a binary select code with round-robin
// arbitration, holding each granted code under a valid/ack handshake and
// counting multi-hot captures in a saturating error counter.
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   req     [N_REQ-1:0] request lines (one-hot expected, multi-hot tolerated)
//   ack                 consumer accepts the current code (ignored while !valid)
//   code    [CODE_W-1:0] granted index, zero-extended
//   valid               code holds a granted index
//   multi               more than one req bit was set at capture
//   err_cnt [ERR_W-1:0] saturating count of multi-hot captures
// ---------------------------------------------------------------------------
module rr_encoder
    import rr_encoder_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int CODE_W = 3,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              multi,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int PTR_W = clog2(N_REQ);

    state_t            r_state_reg, w_state_next;
    logic [PTR_W-1:0]  r_ptr_reg,   w_ptr_next;
    logic [PTR_W-1:0]  r_grant_reg, w_grant_next;
    logic              r_multi_reg, w_multi_next;
    logic [ERR_W-1:0]  r_err_reg,   w_err_next;

    logic [PTR_W-1:0]  w_inc;
    logic [PTR_W-1:0]  w_pick_ptr;
    logic [PTR_W-1:0]  w_grant;
    logic              w_any;
    logic              w_multi_hot;
    logic              w_capture;

    // Pointer after an accepted grant: one past the granted line, wrapping.
    assign w_inc = (r_grant_reg == PTR_W'(N_REQ - 1)) ? '0 : r_grant_reg + 1'b1;

    // A back-to-back capture on the ack edge must already search from the
    // advanced pointer, so the picker sees the pointer's next value.
    assign w_pick_ptr  = (r_state_reg == HOLD && ack) ? w_inc : r_ptr_reg;
    assign w_multi_hot = multi_hot(REQ_MAX_W'(req));

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .grant (w_grant),
        .any   (w_any)
    );

    always_comb begin
        w_state_next = r_state_reg;
        w_ptr_next   = r_ptr_reg;
        w_grant_next = r_grant_reg;
        w_multi_next = r_multi_reg;
        w_err_next   = r_err_reg;
        w_capture    = 1'b0;

        case (r_state_reg)
            IDLE: begin
                if (w_any) begin
                    w_capture    = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    w_ptr_next = w_inc;
                    if (w_any) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_capture) begin
            w_grant_next = w_grant;
            w_multi_next = w_multi_hot;
            if (w_multi_hot && (r_err_reg != '1)) begin
                w_err_next = r_err_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= IDLE;
            r_ptr_reg   <= '0;
            r_grant_reg <= '0;
            r_multi_reg <= 1'b0;
            r_err_reg   <= '0;
        end else begin
            r_state_reg <= w_state_next;
            r_ptr_reg   <= w_ptr_next;
            r_grant_reg <= w_grant_next;
            r_multi_reg <= w_multi_next;
            r_err_reg   <= w_err_next;
        end
    end

    assign code    = CODE_W'(r_grant_reg);
    assign valid   = (r_state_reg == HOLD);
    assign multi   = r_multi_reg;
    assign err_cnt = r_err_reg;

endmodule

// File: tb/tb_rr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_encoder
// Directed bench for rr_encoder. Two instances share stimulus: dut_a with the
// default 8-bit error counter, dut_b with a 2-bit counter for saturation.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_rr_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;

    logic [2:0] code_a;
    logic       valid_a;
    logic       multi_a;
    logic [7:0] err_a;

    logic [2:0] code_b;
    logic       valid_b;
    logic       multi_b;
    logic [1:0] err_b;

    int total_cnt;
    int bad_cnt;

    rr_encoder #(.N_REQ(4), .CODE_W(3), .ERR_W(8)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .code    (code_a),
        .valid   (valid_a),
        .multi   (multi_a),
        .err_cnt (err_a)
    );

    rr_encoder #(.N_REQ(4), .CODE_W(3), .ERR_W(2)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .code    (code_b),
        .valid   (valid_b),
        .multi   (multi_b),
        .err_cnt (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decoder #(3,4) stand-in: binary code to one-hot line select.
    function automatic logic [3:0] decode(input logic [2:0] c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Expected values for the round-robin run with req=1011 under ack
    logic [2:0] rr_code [4] = '{3'd0, 3'd1, 3'd3, 3'd0};
    logic [1:0] sat_err [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [2:0] sat_code[5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b1;
        req = 4'b1111;
        ack = 1'b1;

        // 1. reset holds everything clear despite busy inputs
        step();
        step();
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_code",  32'(code_a),  32'd0);
        chk("rst_multi", 32'(multi_a), 32'd0);
        chk("rst_err",   32'(err_a),   32'd0);
        rst = 1'b0;
        req = 4'b0000;
        ack = 1'b1;

        // ack while idle has no effect
        step();
        chk("idle_ack_valid", 32'(valid_a), 32'd0);

        // 2. single request, latency 1, decode round-trip
        ack = 1'b0;
        req = 4'b0100;
        step();
        chk("single_valid", 32'(valid_a), 32'd1);
        chk("single_code",  32'(code_a),  32'd2);
        chk("single_multi", 32'(multi_a), 32'd0);
        chk("single_decode", 32'(decode(code_a)), 32'b0100);
        ack = 1'b1;
        req = 4'b0000;
        step();
        chk("release_valid", 32'(valid_a), 32'd0);
        chk("release_code",  32'(code_a),  32'd2);
        ack = 1'b0;

        // 3. round robin under continuous ack
        do_reset();
        req = 4'b1011;
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rr_code%0d", i),  32'(code_a),  32'(rr_code[i]));
            chk($sformatf("rr_valid%0d", i), 32'(valid_a), 32'd1);
            chk($sformatf("rr_multi%0d", i), 32'(multi_a), 32'd1);
            chk($sformatf("rr_err%0d", i),   32'(err_a),   32'(i + 1));
        end

        // 4. hold stability: reach code 001, then freeze with ack low
        step();
        chk("hold_pre_code", 32'(code_a), 32'd1);
        ack = 1'b0;
        req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("hold_code%0d", i),  32'(code_a),  32'd1);
            chk($sformatf("hold_valid%0d", i), 32'(valid_a), 32'd1);
        end
        ack = 1'b1;
        step();
        chk("hold_next_code",  32'(code_a),  32'd3);
        chk("hold_next_multi", 32'(multi_a), 32'd0);
        chk("hold_next_err",   32'(err_a),   32'd5);
        req = 4'b0000;
        step();
        chk("hold_end_valid", 32'(valid_a), 32'd0);
        ack = 1'b0;

        // 5. saturation of the 2-bit counter
        do_reset();
        req = 4'b0011;
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sat_err%0d", i),  32'(err_b),  32'(sat_err[i]));
            chk($sformatf("sat_code%0d", i), 32'(code_b), 32'(sat_code[i]));
            chk($sformatf("wide_err%0d", i), 32'(err_a),  32'(i + 1));
        end
        chk("sat_valid", 32'(valid_b), 32'd1);
        chk("sat_multi", 32'(multi_b), 32'd1);
        req = 4'b0000;
        step();
        ack = 1'b0;

        // 6. reset mid-HOLD discards the grant and the pointer
        do_reset();
        req = 4'b0100;
        step();
        chk("mid_pre_code",  32'(code_a),  32'd2);
        chk("mid_pre_valid", 32'(valid_a), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(valid_a), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk("mid_after_code",  32'(code_a),  32'd0);
        chk("mid_after_valid", 32'(valid_a), 32'd1);
        chk("mid_after_multi", 32'(multi_a), 32'd1);
        chk("mid_after_err",   32'(err_a),   32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/rr_encoder.md
Name: rr_encoder

Overview:
- Encoder counterpart to the segment-select decoder: converts N request/enable lines into a binary select code that the decoder can consume, so encode→decode round-trips.
- Sits between instrument/segment request lines and the IJTAG select path.
- Round-robin arbitrates when more than one line is active.
- Holds the granted code stable under a valid/ack handshake.
- Counts multi-hot captures in a saturating counter, which serves as a security/error indicator.

Parameters:
- N_REQ, 4, number of request lines (≥2).
- CODE_W, 3, width of the output code; must satisfy CODE_W ≥ clog2(N_REQ); upper code bits are zero-extended.
- ERR_W, 8, width of the saturating multi-hot error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request lines; the one-hot case is expected, multi-hot is tolerated.
- ack  input  1  consumer accepts the current code; ignored while valid=0.
- code  output  CODE_W  binary index of the granted request line (registered).
- valid  output  1  code holds a granted index (registered).
- multi  output  1  more than one req bit was set when code was captured (registered).
- err_cnt  output  ERR_W  saturating count of multi-hot captures.

Behaviour:
- All outputs are registered.
- Reset (sampled on a clk edge with rst=1):
  - code=0, valid=0, multi=0, err_cnt=0.
  - Internal pointer ptr=0, state=IDLE.
  - Reset overrides every other input on the same edge.
- States:
  - IDLE: valid=0.
  - HOLD: valid=1.
- Grant selection:
  - grant = first set req bit searching upward from ptr, wrapping N_REQ-1 → 0.
  - code = grant index, zero-extended to CODE_W.
- IDLE, req≠0: capture on the edge.
  - code=grant, multi=(popcount(req)>1), err_cnt+=multi.
  - Go to HOLD, so valid=1 one cycle after req is sampled (latency 1).
- IDLE, req=0: remain in IDLE; outputs unchanged (code keeps its last value).
- HOLD, ack=0:
  - code, multi and valid are frozen.
  - req changes are ignored.
- HOLD, ack=1:
  - ptr ← (code+1) mod N_REQ, with wrap N_REQ-1 → 0.
  - If req≠0 on the same edge: back-to-back capture using the updated ptr. Stay in HOLD with valid held at 1, giving a new code every cycle under continuous ack.
  - If req=0: go to IDLE, valid=0 next cycle, code and multi retain their values.
- ack while valid=0: no effect.
- err_cnt increments only on captures with multi=1, and saturates at 2^ERR_W-1 (no wrap).
- Reset mid-HOLD: valid drops at that edge, ptr returns to 0, and any pending grant is discarded.

Decomposition:
- Shared include/package holds:
  - state localparams IDLE=1'b0, HOLD=1'b1;
  - a clog2 constant function;
  - a popcount>1 helper function.
- One combinational sub-module, rr_pick (req, ptr → grant index, any), holds the rotate/priority logic.
- rr_encoder holds the FSM, registers and counter.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=1111, ack=1 → valid=0, code=000, multi=0, err_cnt=0.
2. Single request, N_REQ=4:
   - req=0100 → next cycle valid=1, code=010, multi=0.
   - ack=1 with req=0000 → valid=0 the following cycle.
   - Route code into decoder #(3,4) → decoder output equals 0100.
3. Round robin: req=1011 held, ack=1 held → successive codes 000, 001, 011, 000 (wrap); multi=1 each capture; err_cnt 1, 2, 3, 4.
4. Hold stability: after code=001 is granted, ack=0 and req changes to 1000 for 5 cycles → code stays 001, valid stays 1. Then ack=1 → next code=011.
5. Saturation, ERR_W=2: 5 multi-hot captures (req=0011, acked each time) → err_cnt sequence 1, 2, 3, 3, 3.
6. Reset mid-HOLD: reach code=010 with valid=1, pulse rst for 1 cycle → valid=0. Then req=1111 → code=000, confirming ptr reset.
